// File: rtl/svga_text_pixel_pipe_pkg.sv
// Shared geometry, cursor window and cell-phase constants for the SVGA text pixel pipeline.
package svga_text_pixel_pipe_pkg;

  localparam int TEXT_COLS         = 32;
  localparam int TEXT_ROWS         = 16;
  localparam int FONT_ROWS         = 12;
  localparam int CURSOR_FIRST_LINE = 20;
  localparam int DOT_W             = 8;

  localparam int COL_W      = $clog2(TEXT_COLS);
  localparam int ROW_W      = $clog2(TEXT_ROWS);
  localparam int FONT_ROW_W = $clog2(FONT_ROWS);

  localparam logic [3:0] SP_VRAM_RD   = 4'd0;
  localparam logic [3:0] SP_CODE      = 4'd2;
  localparam logic [3:0] SP_FONT_ADDR = 4'd3;
  localparam logic [3:0] SP_FONT_Q    = 4'd5;
  localparam logic [3:0] SP_LOAD      = 4'd6;

  // Out-of-range rows/columns wrap by truncation; the border mask hides them.
  function automatic logic [ROW_W+COL_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                       input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/svga_dot_shifter.sv
// Font-row dot shifter: parallel load with optional inversion, MSB-first left shift.
module svga_dot_shifter
  import svga_text_pixel_pipe_pkg::*;
(
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             invert,
  input  logic [DOT_W-1:0] din,
  output logic             dot
);

  logic [DOT_W-1:0] shifter_q, shifter_d;

  always_comb begin
    shifter_d = shifter_q;
    if (load) begin
      shifter_d = din ^ {DOT_W{invert}};
    end else if (shift) begin
      shifter_d = {shifter_q[DOT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      shifter_q <= '0;
    end else begin
      shifter_q <= shifter_d;
    end
  end

  assign dot = shifter_q[DOT_W-1];

endmodule

// File: rtl/svga_text_pixel_pipe.sv
// Text-mode pixel pipeline: per-cell VRAM and font fetch, dot serialisation,
// inverse video, blinking cursor, border/blank mux and sync alignment.
module svga_text_pixel_pipe
  import svga_text_pixel_pipe_pkg::*;
#(
  parameter int RGB_W     = 12,
  parameter int FLASH_BIT = 4
) (
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic             text_en,
  input  logic [6:0]       char_column,
  input  logic [6:0]       char_line,
  input  logic [3:0]       subchar_pixel,
  input  logic [4:0]       subchar_line,
  input  logic             h_synch_in,
  input  logic             v_synch_in,
  input  logic             blank_in,
  input  logic             show_border_in,
  output logic [8:0]       vram_addr,
  output logic             vram_rd,
  input  logic [7:0]       vram_data,
  output logic [10:0]      font_addr,
  input  logic [7:0]       font_data,
  input  logic [RGB_W-1:0] fg_rgb,
  input  logic [RGB_W-1:0] bg_rgb,
  input  logic [RGB_W-1:0] border_rgb,
  input  logic             cursor_en,
  input  logic [8:0]       cursor_addr,
  output logic [RGB_W-1:0] rgb,
  output logic             h_synch_out,
  output logic             v_synch_out,
  output logic             blank_out
);

  logic [8:0]       vram_addr_q, vram_addr_d;
  logic             vram_rd_q, vram_rd_d;
  logic [7:0]       code_q, code_d;
  logic             inv_q, inv_d;
  logic             cur_hit_q, cur_hit_d;
  logic [10:0]      font_addr_q, font_addr_d;
  logic [7:0]       font_q, font_d;
  logic [7:0]       frame_q, frame_d;
  logic             vsync_prev_q, vsync_prev_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             h_synch_q, v_synch_q, blank_q;

  logic shift_load, shift_en, shift_inv, dot;
  logic cursor_window;

  logic unused_bits;
  assign unused_bits = ^{char_column[6:COL_W], char_line[6:ROW_W], subchar_line[0]};

  assign cursor_window = (subchar_line >= 5'(CURSOR_FIRST_LINE));

  always_comb begin
    vram_addr_d  = vram_addr_q;
    vram_rd_d    = 1'b0;
    code_d       = code_q;
    inv_d        = inv_q;
    cur_hit_d    = cur_hit_q;
    font_addr_d  = font_addr_q;
    font_d       = font_q;
    frame_d      = frame_q;
    vsync_prev_d = v_synch_in;
    rgb_d        = bg_rgb;

    // Stage sp=0: issue VRAM read for the cell (repeats harmlessly while sp parks at 0)
    if (subchar_pixel == SP_VRAM_RD) begin
      vram_addr_d = cell_addr(char_line[ROW_W-1:0], char_column[COL_W-1:0]);
      vram_rd_d   = 1'b1;
    end
    // Stage sp=2: capture character code, attribute and cursor match
    if (subchar_pixel == SP_CODE) begin
      code_d    = vram_data;
      inv_d     = vram_data[7];
      cur_hit_d = cursor_en && (vram_addr_q == cursor_addr);
    end
    // Stage sp=3: font row address; each font row spans two scan lines
    if (subchar_pixel == SP_FONT_ADDR) begin
      font_addr_d = {code_q[6:0], subchar_line[FONT_ROW_W:1]};
    end
    // Stage sp=5: capture font row
    if (subchar_pixel == SP_FONT_Q) begin
      font_d = font_data;
    end

    if (v_synch_in && !vsync_prev_q) begin
      frame_d = frame_q + 8'd1;
    end

    // Output stage: colour select, blank dominates border dominates text
    if (blank_in) begin
      rgb_d = '0;
    end else if (show_border_in) begin
      rgb_d = border_rgb;
    end else if (!text_en) begin
      rgb_d = bg_rgb;
    end else if (dot) begin
      rgb_d = fg_rgb;
    end else begin
      rgb_d = bg_rgb;
    end
  end

  // Stage sp=6 loads the shifter; every other even phase shifts, giving 2-clock dots
  assign shift_load = (subchar_pixel == SP_LOAD);
  assign shift_en   = !subchar_pixel[0] && !shift_load;
  assign shift_inv  = inv_q ^ (cur_hit_q & frame_q[FLASH_BIT] & cursor_window);

  svga_dot_shifter u_dot_shifter (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .load        (shift_load),
    .shift       (shift_en),
    .invert      (shift_inv),
    .din         (font_q),
    .dot         (dot)
  );

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      vram_addr_q  <= '0;
      vram_rd_q    <= 1'b0;
      code_q       <= '0;
      inv_q        <= 1'b0;
      cur_hit_q    <= 1'b0;
      font_addr_q  <= '0;
      font_q       <= '0;
      frame_q      <= '0;
      vsync_prev_q <= 1'b0;
      rgb_q        <= '0;
      h_synch_q    <= 1'b0;
      v_synch_q    <= 1'b0;
      blank_q      <= 1'b0;
    end else begin
      vram_addr_q  <= vram_addr_d;
      vram_rd_q    <= vram_rd_d;
      code_q       <= code_d;
      inv_q        <= inv_d;
      cur_hit_q    <= cur_hit_d;
      font_addr_q  <= font_addr_d;
      font_q       <= font_d;
      frame_q      <= frame_d;
      vsync_prev_q <= vsync_prev_d;
      rgb_q        <= rgb_d;
      h_synch_q    <= h_synch_in;
      v_synch_q    <= v_synch_in;
      blank_q      <= blank_in;
    end
  end

  assign vram_addr   = vram_addr_q;
  assign vram_rd     = vram_rd_q;
  assign font_addr   = font_addr_q;
  assign rgb         = rgb_q;
  assign h_synch_out = h_synch_q;
  assign v_synch_out = v_synch_q;
  assign blank_out   = blank_q;

endmodule

// File: tb/tb_svga_text_pixel_pipe.sv
// Directed bench for svga_text_pixel_pipe with behavioural sync VRAM and font ROM.
module tb_svga_text_pixel_pipe;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        text_en = 1'b0;
  logic [6:0]  char_column = '0;
  logic [6:0]  char_line = '0;
  logic [3:0]  subchar_pixel = '0;
  logic [4:0]  subchar_line = '0;
  logic        h_synch_in = 1'b0;
  logic        v_synch_in = 1'b0;
  logic        blank_in = 1'b0;
  logic        show_border_in = 1'b0;
  logic [8:0]  vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [11:0] fg_rgb = 12'h0F0;
  logic [11:0] bg_rgb = 12'h00F;
  logic [11:0] border_rgb = 12'hF00;
  logic        cursor_en = 1'b0;
  logic [8:0]  cursor_addr = '0;
  logic [11:0] rgb;
  logic        h_synch_out, v_synch_out, blank_out;

  logic [7:0]  vram [0:511];
  logic [7:0]  font [0:2047];
  logic [11:0] rgb_log [0:4095];
  logic [10:0] last_fa;
  int e = 0;
  int vectors = 0;
  int miscompares = 0;

  svga_text_pixel_pipe #(.RGB_W(12), .FLASH_BIT(4)) dut (
    .pixel_clock    (pixel_clock),
    .reset          (reset),
    .text_en        (text_en),
    .char_column    (char_column),
    .char_line      (char_line),
    .subchar_pixel  (subchar_pixel),
    .subchar_line   (subchar_line),
    .h_synch_in     (h_synch_in),
    .v_synch_in     (v_synch_in),
    .blank_in       (blank_in),
    .show_border_in (show_border_in),
    .vram_addr      (vram_addr),
    .vram_rd        (vram_rd),
    .vram_data      (vram_data),
    .font_addr      (font_addr),
    .font_data      (font_data),
    .fg_rgb         (fg_rgb),
    .bg_rgb         (bg_rgb),
    .border_rgb     (border_rgb),
    .cursor_en      (cursor_en),
    .cursor_addr    (cursor_addr),
    .rgb            (rgb),
    .h_synch_out    (h_synch_out),
    .v_synch_out    (v_synch_out),
    .blank_out      (blank_out)
  );

  always #5 pixel_clock = ~pixel_clock;

  // Synchronous memories: data appears the edge after the address/strobe is presented
  always @(posedge pixel_clock) begin
    if (vram_rd) vram_data <= vram[vram_addr];
    font_data <= font[font_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
    e++;
    if (e < 4096) rgb_log[e] = rgb;
  endtask

  task automatic run_cell(input int col, input int line, input int sline, output int e0);
    e0 = 0;
    for (int sp = 0; sp < 16; sp++) begin
      char_column   = 7'(col);
      char_line     = 7'(line);
      subchar_line  = 5'(sline);
      subchar_pixel = 4'(sp);
      tick();
      if (sp == 0) begin
        e0 = e;
        chk("cell_vram_addr", 32'(vram_addr), 32'({line[3:0], col[4:0]}));
        chk("cell_vram_rd_hi", 32'(vram_rd), 32'd1);
      end
      if (sp == 1) chk("cell_vram_rd_lo", 32'(vram_rd), 32'd0);
      if (sp == 3) last_fa = font_addr;
    end
  endtask

  task automatic check_row(input string tag, input int e0, input logic [7:0] pat);
    for (int p = 0; p < 16; p++)
      chk(tag, 32'(rgb_log[e0+7+p]), 32'(pat[7-p/2] ? fg_rgb : bg_rgb));
  endtask

  task automatic check_flat(input string tag, input int e0, input logic [11:0] exp);
    for (int p = 0; p < 16; p++)
      chk(tag, 32'(rgb_log[e0+p]), 32'(exp));
  endtask

  task automatic vpulse();
    subchar_pixel = 4'd1;
    v_synch_in = 1'b1;
    tick();
    v_synch_in = 1'b0;
    tick();
  endtask

  initial begin
    int ea, eb, ec, ef, e1, e2, e3, e4, e5, e6, e7, ex, ebk, ebd, etx, e6x, er;

    for (int i = 0; i < 512; i++) vram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) font[i] = 8'h00;
    vram[9'h000] = 8'h41;
    vram[9'h001] = 8'hC1;
    vram[9'h025] = 8'h42;
    vram[9'h026] = 8'h42;
    font[{7'h41, 4'd0}]  = 8'h81;
    font[{7'h41, 4'd2}]  = 8'h18;
    font[{7'h42, 4'd9}]  = 8'h3C;
    font[{7'h42, 4'd10}] = 8'h3C;
    font[{7'h42, 4'd11}] = 8'h3C;

    // Reset state with live inputs that would otherwise propagate
    h_synch_in = 1'b1;
    v_synch_in = 1'b1;
    blank_in   = 1'b1;
    repeat (3) tick();
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_vram_rd", 32'(vram_rd), 32'd0);
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    chk("rst_font_addr", 32'(font_addr), 32'd0);
    chk("rst_h_synch_out", 32'(h_synch_out), 32'd0);
    chk("rst_v_synch_out", 32'(v_synch_out), 32'd0);
    chk("rst_blank_out", 32'(blank_out), 32'd0);
    reset = 1'b0;
    h_synch_in = 1'b0;
    v_synch_in = 1'b0;
    blank_in = 1'b0;
    text_en = 1'b1;

    // Plain cell, inverse-attribute cell, second font row
    run_cell(0, 0, 0, ea);
    chk("t2_font_addr", 32'(last_fa), 32'h410);
    run_cell(1, 0, 0, eb);
    run_cell(0, 0, 5, ec);
    chk("row2_font_addr", 32'(last_fa), 32'h412);
    run_cell(2, 0, 0, ef);
    check_row("t2_row", ea, 8'h81);
    check_row("t3_inv", eb, 8'h7E);
    check_row("row2", ec, 8'h18);

    // Cursor at cell (5,1): blink phase from frame bit 4
    cursor_en = 1'b1;
    cursor_addr = 9'h025;
    run_cell(5, 1, 20, e1);
    run_cell(2, 0, 0, ef);
    check_row("t4_cur_phase0", e1, 8'h3C);
    repeat (16) vpulse();
    run_cell(5, 1, 20, e2);
    run_cell(5, 1, 19, e3);
    run_cell(6, 1, 20, e4);
    run_cell(5, 1, 22, e5);
    cursor_en = 1'b0;
    run_cell(5, 1, 23, e6);
    run_cell(2, 0, 0, ef);
    check_row("t4_cur_on", e2, 8'hC3);
    check_row("t4_above_window", e3, 8'h3C);
    check_row("t4_other_cell", e4, 8'h3C);
    check_row("t4_cur_line22", e5, 8'hC3);
    check_row("t4_cur_disabled", e6, 8'h3C);
    repeat (16) vpulse();
    cursor_en = 1'b1;
    run_cell(5, 1, 21, e7);
    run_cell(2, 0, 0, ef);
    check_row("t4_cur_phase_back", e7, 8'h3C);

    // Sync/blank delay is exactly one clock
    subchar_pixel = 4'd1;
    h_synch_in = 1'b1;
    blank_in = 1'b1;
    chk("t5_h_before_edge", 32'(h_synch_out), 32'd0);
    tick();
    chk("t5_h_delayed", 32'(h_synch_out), 32'd1);
    chk("t5_blank_delayed", 32'(blank_out), 32'd1);
    chk("t5_v_low", 32'(v_synch_out), 32'd0);
    h_synch_in = 1'b0;
    v_synch_in = 1'b1;
    blank_in = 1'b0;
    tick();
    chk("t5_h_fall", 32'(h_synch_out), 32'd0);
    chk("t5_v_delayed", 32'(v_synch_out), 32'd1);
    chk("t5_blank_fall", 32'(blank_out), 32'd0);
    v_synch_in = 1'b0;
    tick();
    chk("t5_v_fall", 32'(v_synch_out), 32'd0);

    // Blank, border and renderer-disabled override visible dots
    run_cell(0, 0, 0, ex);
    blank_in = 1'b1;
    run_cell(0, 0, 0, ebk);
    blank_in = 1'b0;
    show_border_in = 1'b1;
    run_cell(0, 0, 0, ebd);
    show_border_in = 1'b0;
    text_en = 1'b0;
    run_cell(0, 0, 0, etx);
    text_en = 1'b1;
    check_flat("t5_blank", ebk, 12'h000);
    check_flat("t5_border", ebd, 12'hF00);
    check_flat("t5_text_off", etx, 12'h00F);

    // Out-of-range column/row wrap under the border
    show_border_in = 1'b1;
    run_cell(33, 17, 0, e6x);
    chk("t6_vram_addr", 32'(vram_addr), 32'h021);
    run_cell(2, 0, 0, ef);
    show_border_in = 1'b0;
    check_flat("t6_border", e6x, 12'hF00);

    // Reset asserted mid-cell, then a clean cell after release
    run_cell(0, 0, 0, ef);
    h_synch_in = 1'b1;
    for (int sp = 0; sp < 5; sp++) begin
      subchar_pixel = 4'(sp);
      tick();
    end
    chk("t1_pre_h_synch_out", 32'(h_synch_out), 32'd1);
    reset = 1'b1;
    #1;
    chk("t1_mid_rgb", 32'(rgb), 32'd0);
    chk("t1_mid_vram_rd", 32'(vram_rd), 32'd0);
    chk("t1_mid_font_addr", 32'(font_addr), 32'd0);
    chk("t1_mid_h_synch_out", 32'(h_synch_out), 32'd0);
    repeat (2) tick();
    chk("t1_held_rgb", 32'(rgb), 32'd0);
    chk("t1_held_h_synch_out", 32'(h_synch_out), 32'd0);
    reset = 1'b0;
    h_synch_in = 1'b0;
    run_cell(0, 0, 0, er);
    run_cell(2, 0, 0, ef);
    check_row("t1_after_release", er, 8'h81);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
